// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EX stage: ALU/MEM op codes plus the encodings and
// constants used by the iterative divider controller.
package div_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_LH   = 3'd3,
    MEM_LHU  = 3'd4,
    MEM_LW   = 3'd5,
    MEM_SB   = 3'd6,
    MEM_SW   = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_e;

  localparam int unsigned DIV_ITER  = 32;
  localparam int unsigned DIV_RES_W = 64;
  localparam int unsigned DIV_CNT_W = 6;

  // Two's-complement negate when neg is set; 0x80000000 maps to itself.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_div_step.sv
// div_step: one restoring shift-subtract iteration (combinational).
// Ports:
//   work_i    [63:0] {partial remainder, dividend/quotient bits}
//   divisor_i [31:0] divisor magnitude
//   work_o    [63:0] working register after one iteration
module div_step (
  input  logic [63:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] work_o
);

  // Shifted remainder needs 33 bits: remainder < divisor, so 2*rem+1 can
  // exceed 32 bits for large divisors.
  logic [32:0] rem_shift;
  logic [32:0] diff;

  assign rem_shift = work_i[63:31];
  assign diff      = rem_shift - {1'b0, divisor_i};

  always_comb begin
    work_o = {rem_shift[31:0], work_i[30:0], 1'b0};
    if (rem_shift >= {1'b0, divisor_i}) begin
      work_o = {diff[31:0], work_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: iterative 32-bit signed/unsigned divider controller for EX.
// Ports:
//   clk, rst (sync, active-high)
//   start_i    divide request, held until result consumed
//   cancel_i   abort in-flight divide (pipeline flush)
//   signed_i   1 = DIV, 0 = DIVU
//   dividend_i, divisor_i  32-bit operands
//   result_o   {remainder, quotient}
//   ready_o    result_o valid
//
// state   | meaning
// IDLE    | waiting for start_i
// BY_ZERO | divisor was zero, result forced to 0
// ON      | 32 shift-subtract iterations, then sign fix
// END     | result valid, held until start_i drops
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 cancel_i,
  input  logic                 signed_i,
  input  logic [31:0]          dividend_i,
  input  logic [31:0]          divisor_i,
  output logic [DIV_RES_W-1:0] result_o,
  output logic                 ready_o
);

  div_state_e            state_q, state_d;
  logic [DIV_CNT_W-1:0]  count_q, count_d;
  logic [63:0]           work_q, work_d;
  logic [31:0]           divisor_q, divisor_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DIV_RES_W-1:0]  result_q, result_d;
  logic                  ready_q, ready_d;
  logic [63:0]           step_work;
  logic                  dvd_neg, dvs_neg;

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  assign dvd_neg = signed_i & dividend_i[31];
  assign dvs_neg = signed_i & divisor_i[31];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !cancel_i) begin
          if (divisor_i == 32'd0) begin
            state_d = BY_ZERO;
          end else begin
            state_d   = ON;
            count_d   = '0;
            work_d    = {32'd0, cond_neg(dividend_i, dvd_neg)};
            divisor_d = cond_neg(divisor_i, dvs_neg);
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
          end
        end
      end
      BY_ZERO: begin
        state_d  = END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (count_q < DIV_CNT_W'(DIV_ITER)) begin
          work_d  = step_work;
          count_d = count_q + 1'b1;
        end else begin
          state_d  = END;
          result_d = {cond_neg(work_q[63:32], neg_rem_q),
                      cond_neg(work_q[31:0], neg_quo_q)};
          ready_d  = 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase

    // Flush wins over every other transition.
    if (cancel_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      count_d  = '0;
      ready_d  = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        cancel_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  // Inputs change 1 time unit after a rising edge; the next edge samples them.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
  endtask

  // Counts edges until ready_o is seen; bounded at 100.
  task automatic wait_ready(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (ready_o === 1'b1 || lat >= 100) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; cancel_i = 1'b1; signed_i = 1'b1;
    dividend_i = 32'd50; divisor_i = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
    start_i = 1'b0; cancel_i = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_100_7();
    int lat;
    start_div(32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;   // E0
    wait_ready(lat);
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL u100_7 latency: got %0d, want 33", lat);
    end
    n_checks++;
    if (result_o !== 64'h00000002_0000000E) begin
      n_fail++;
      $display("FAIL u100_7 result: got %h, want 000000020000000e", result_o);
    end
    // Operand changes while held in END must not disturb the result.
    dividend_i = 32'd1; divisor_i = 32'd1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
        n_fail++;
        $display("FAIL u100_7 hold: ready=%b result=%h, want 1 / 000000020000000e", ready_o, result_o);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL u100_7 release: ready=%b result=%h, want 0 / 0", ready_o, result_o);
    end
  endtask

  task automatic test_vectors();
    vec_t v[7];
    int   lat;
    v[0] = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD};  // -7/2
    v[1] = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD};  // 7/-2
    v[2] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFF_00000003};  // -7/-2
    v[3] = '{32'hFFFFFFF9, 32'h00000002, 1'b0, 64'h00000001_7FFFFFFC};  // unsigned
    v[4] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000};  // overflow wrap
    v[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000};
    v[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001};
    for (int i = 0; i < 7; i++) begin
      start_div(v[i].a, v[i].b, v[i].s);
      @(posedge clk); #1;
      wait_ready(lat);
      n_checks++;
      if (lat !== 33 || result_o !== v[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: lat=%0d result=%h, want lat=33 result=%h", i, lat, result_o, v[i].exp);
      end
      start_i = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_by_zero();
    int lat;
    start_div(32'h00001234, 32'd0, 1'b0);
    @(posedge clk); #1;
    wait_ready(lat);
    n_checks++;
    if (lat !== 1 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL by_zero: lat=%0d result=%h, want lat=1 result=0", lat, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL by_zero release: ready=%b, want 0", ready_o);
    end
  endtask

  task automatic test_cancel();
    int lat;
    int seen;
    start_div(32'd1000, 32'd7, 1'b0);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    cancel_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL cancel: ready=%b result=%h, want 0 / 0", ready_o, result_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL cancel no_result: ready seen %0d cycles, want 0", seen);
    end
    start_div(32'd9, 32'd3, 1'b0);
    @(posedge clk); #1;
    wait_ready(lat);
    n_checks++;
    if (lat !== 33 || result_o !== 64'h00000000_00000003) begin
      n_fail++;
      $display("FAIL cancel 9_3: lat=%0d result=%h, want 33 / 0000000000000003", lat, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    start_div(32'd12345, 32'd10, 1'b0);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; cancel_i = 1'b1;
    start_div(32'd1000, 32'd33, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b result=%h, want 0 / 0", ready_o, result_o);
    end
    rst = 1'b0; cancel_i = 1'b0;
    @(posedge clk); #1;   // new E0, operands 1000/33 captured
    dividend_i = 32'd5; divisor_i = 32'd5; signed_i = 1'b1;
    wait_ready(lat);
    n_checks++;
    if (lat !== 33 || result_o !== 64'h0000000A_0000001E) begin
      n_fail++;
      $display("FAIL reset_mid restart: lat=%0d result=%h, want 33 / 0000000a0000001e", lat, result_o);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h0000000A_0000001E) begin
        n_fail++;
        $display("FAIL reset_mid hold: ready=%b result=%h, want 1 / 0000000a0000001e", ready_o, result_o);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid release: ready=%b result=%h, want 0 / 0", ready_o, result_o);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_100_7();
    test_vectors();
    test_by_zero();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start_i  input  1  divide request from EX; held high until result is consumed.
REQ-004 SHALL have port cancel_i  input  1  abort in-flight divide (pipeline flush).
REQ-005 SHALL have port signed_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
REQ-006 SHALL have port dividend_i  input  32  dividend operand.
REQ-007 SHALL have port divisor_i  input  32  divisor operand.
REQ-008 SHALL have port result_o  output  64  {remainder, quotient}, HI in [63:32], LO in [31:0].
REQ-009 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-010 SHALL implement FSM states IDLE, BY_ZERO, ON, END; result_o and ready_o registered.
REQ-011 IDLE: start_i=1, cancel_i=0, divisor_i!=0 -> ON, capture operands, iteration count = 0.
REQ-012 IDLE: start_i=1, cancel_i=0, divisor_i=0 -> BY_ZERO; the next edge -> END with result_o=0.
REQ-013 Operand capture in signed mode: each negative operand SHALL be replaced by its two's-complement magnitude; the original signs SHALL be latched.
REQ-014 Operands SHALL be sampled only at the IDLE exit edge; later input changes are ignored.
REQ-015 ON: each edge with count<32 performs one restoring shift-subtract step (33-bit compare of partial remainder vs divisor), count+1.
REQ-016 ON with count=32: apply sign fix and go to END; quotient negated if the signs differ; remainder takes the dividend sign (signed mode only).
REQ-017 Latency: start sampled at edge E0 -> ready_o=1 after E33 (normal) or after E1 (divide by zero).
REQ-018 END: ready_o=1, result_o held stable while start_i=1; start_i=0 -> IDLE, ready_o=0, result_o=0.
REQ-019 cancel_i=1 in any non-IDLE state SHALL force IDLE at that edge, with ready_o=0, result_o=0 and no result delivered; cancel_i has priority over all other transitions.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-021 ready_o SHALL never assert outside END; a new divide SHALL require a return to IDLE first (start_i low for at least one cycle).

Reset
REQ-022 rst=1 at an edge SHALL force IDLE with count=0, ready_o=0, result_o=0, and captured operands/signs=0, from any state including mid-divide.
REQ-023 rst SHALL take priority over cancel_i and start_i.

Structure
REQ-024 The state encodings (2-bit), the iteration limit constant (32) and the result width (64) SHALL live in the shared defines package alongside the ALU/MEM op codes.
REQ-025 One combinational sub-module, div_step, SHALL perform a single shift-subtract iteration: 64-bit working register in, divisor in, next working register out.
REQ-026 EX drives start_i/signed_i/operands, consumes result_o/ready_o, and drives its pause request from start_i && !ready_o.

Verification
REQ-027 Unsigned 100/7: start held -> ready_o rises 33 cycles later, result_o=0x00000002_0000000E.
REQ-028 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD.
REQ-029 Divisor 0 with dividend 0x1234 -> ready_o after 1 cycle in BY_ZERO, result_o=0.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000.
REQ-031 cancel_i pulsed 10 cycles after start -> IDLE next edge; ready_o stays 0; a subsequent 9/3 divide returns 0x00000000_00000003.
REQ-032 rst asserted at iteration 20, then start_i held with operands changed mid-run -> divide restarts from IDLE; result reflects the operands captured at the new start only; ready_o held until start_i drops.
